// File: rtl/access_control_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : access_control_unit_pkg
//  Description : Shared status codes, FSM state encoding and stored password
//                for the access-control responder.
//  Revision    : 1.0 - initial release
// ============================================================================
package access_control_unit_pkg;

    // Status codes presented to the LCD/LED driver
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ENTRY   = 3'd1;
    localparam logic [2:0] ST_GRANTED = 3'd2;
    localparam logic [2:0] ST_DENIED  = 3'd3;
    localparam logic [2:0] ST_LOCKED  = 3'd4;

    // Controller states; CHECK is a one-cycle compare step shown as ENTRY
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ENTRY   = 3'd1,
        S_CHECK   = 3'd2,
        S_GRANTED = 3'd3,
        S_DENIED  = 3'd4,
        S_LOCKED  = 3'd5
    } acu_state_e;

    // Stored password, most significant digit entered first
    localparam logic [15:0] DEFAULT_PW = 16'h1234;

endpackage : access_control_unit_pkg
`default_nettype wire

// File: rtl/access_control_unit_button_edge.sv
`default_nettype none
// ============================================================================
//  Module      : button_edge
//  Description : Rising-edge press detector for one debounced button level.
//                History resets to 1 so a button held through reset is not
//                seen as a press; history tracks the button even when the
//                block is disabled.
//  Revision    : 1.0 - initial release
// ============================================================================
module button_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_enable,
    input  logic i_btn,
    output logic o_press
);

    logic r_prev;

    // Button history, updated every cycle regardless of enable
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prev <= 1'b1;
        end else begin
            r_prev <= i_btn;
        end
    end

    assign o_press = i_enable & i_btn & ~r_prev;

endmodule : button_edge
`default_nettype wire

// File: rtl/access_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : access_control_unit
//  Description : Password entry responder. Collects PW_LEN digits from the
//                switches, compares against the stored password, reports a
//                granted session and enforces a retry limit with lockout.
//                PW_LEN must be at least 2.
//  Revision    : 1.0 - initial release
// ============================================================================
module access_control_unit #(
    parameter int DIGIT_W     = 4,
    parameter int PW_LEN      = 4,
    parameter int MAX_TRIES   = 3,
    parameter int DENY_CYCLES = 8,
    parameter int LOCK_CYCLES = 32,
    parameter logic [PW_LEN*DIGIT_W-1:0] DEFAULT_PW = access_control_unit_pkg::DEFAULT_PW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               access_control_reset,
    input  logic [DIGIT_W-1:0] switches,
    input  logic               btn_enter,
    input  logic               btn_clear,
    output logic               access_control_fb,
    output logic [2:0]         status,
    output logic [2:0]         digit_count,
    output logic [1:0]         tries_left,
    output logic               lockout
);

    import access_control_unit_pkg::*;

    localparam int c_pw_w    = PW_LEN * DIGIT_W;
    localparam int c_tmr_max = (DENY_CYCLES > LOCK_CYCLES) ? DENY_CYCLES : LOCK_CYCLES;
    localparam int c_tmr_w   = (c_tmr_max > 1) ? $clog2(c_tmr_max) : 1;

    localparam logic [2:0]         c_pw_len    = 3'(PW_LEN);
    localparam logic [1:0]         c_tries_max = 2'(MAX_TRIES);
    localparam logic [c_tmr_w-1:0] c_deny_load = c_tmr_w'(DENY_CYCLES - 1);
    localparam logic [c_tmr_w-1:0] c_lock_load = c_tmr_w'(LOCK_CYCLES - 1);

    acu_state_e          r_state;
    logic [2:0]          r_status;
    logic                r_fb;
    logic                r_lockout;
    logic [2:0]          r_count;
    logic [1:0]          r_tries;
    logic [c_pw_w-1:0]   r_buf;
    logic [c_tmr_w-1:0]  r_timer;

    logic                w_enter_press;
    logic                w_clear_press;
    logic [2:0]          w_count_inc;

    button_edge u_enter_edge (
        .clk      (clk),
        .rst      (rst),
        .i_enable (enable),
        .i_btn    (btn_enter),
        .o_press  (w_enter_press)
    );

    button_edge u_clear_edge (
        .clk      (clk),
        .rst      (rst),
        .i_enable (enable),
        .i_btn    (btn_clear),
        .o_press  (w_clear_press)
    );

    assign w_count_inc = r_count + 3'd1;

    // Session FSM with registered status/feedback outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_status  <= ST_IDLE;
            r_fb      <= 1'b0;
            r_lockout <= 1'b0;
            r_count   <= 3'd0;
            r_tries   <= c_tries_max;
            r_buf     <= '0;
            r_timer   <= '0;
        end else if (r_state == S_LOCKED) begin
            // Lockout ignores the controller's session clear and all buttons
            if (r_timer == '0) begin
                r_state   <= S_IDLE;
                r_status  <= ST_IDLE;
                r_lockout <= 1'b0;
                r_tries   <= c_tries_max;
            end else begin
                r_timer <= r_timer - c_tmr_w'(1);
            end
        end else if (!access_control_reset) begin
            // Session clear from the controller; retry budget is kept
            r_state  <= S_IDLE;
            r_status <= ST_IDLE;
            r_fb     <= 1'b0;
            r_count  <= 3'd0;
            r_buf    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_enter_press && !w_clear_press) begin
                        r_buf    <= {{(c_pw_w-DIGIT_W){1'b0}}, switches};
                        r_count  <= 3'd1;
                        r_status <= ST_ENTRY;
                        r_state  <= (c_pw_len == 3'd1) ? S_CHECK : S_ENTRY;
                    end
                end
                S_ENTRY: begin
                    if (w_clear_press) begin
                        r_buf   <= '0;
                        r_count <= 3'd0;
                        if (r_count == 3'd0) begin
                            r_state  <= S_IDLE;
                            r_status <= ST_IDLE;
                        end
                    end else if (w_enter_press) begin
                        r_buf   <= {r_buf[c_pw_w-DIGIT_W-1:0], switches};
                        r_count <= w_count_inc;
                        if (w_count_inc == c_pw_len) begin
                            r_state <= S_CHECK;
                        end
                    end
                end
                S_CHECK: begin
                    r_count <= 3'd0;
                    r_buf   <= '0;
                    if (r_buf == DEFAULT_PW) begin
                        r_state  <= S_GRANTED;
                        r_status <= ST_GRANTED;
                        r_fb     <= 1'b1;
                        r_tries  <= c_tries_max;
                    end else if (r_tries > 2'd1) begin
                        r_state  <= S_DENIED;
                        r_status <= ST_DENIED;
                        r_tries  <= r_tries - 2'd1;
                        r_timer  <= c_deny_load;
                    end else begin
                        r_state   <= S_LOCKED;
                        r_status  <= ST_LOCKED;
                        r_lockout <= 1'b1;
                        r_tries   <= 2'd0;
                        r_timer   <= c_lock_load;
                    end
                end
                S_DENIED: begin
                    if (r_timer == '0) begin
                        r_state  <= S_IDLE;
                        r_status <= ST_IDLE;
                    end else begin
                        r_timer <= r_timer - c_tmr_w'(1);
                    end
                end
                default: begin
                    // GRANTED holds until the controller clears the session
                end
            endcase
        end
    end

    assign access_control_fb = r_fb;
    assign status            = r_status;
    assign digit_count       = r_count;
    assign tries_left        = r_tries;
    assign lockout           = r_lockout;

endmodule : access_control_unit
`default_nettype wire

// File: tb/tb_access_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_access_control_unit
//  Description : Self-checking bench for access_control_unit. A behavioural
//                model (digit queue plus countdowns) is compared against the
//                DUT on every falling edge; directed scenarios add literal
//                expectations, followed by randomized traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_access_control_unit;

    localparam int PW_LEN    = 4;
    localparam int MAX_TRIES = 3;
    localparam int DENY      = 8;
    localparam int LOCK      = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       acr;
    logic [3:0] switches;
    logic       btn_enter;
    logic       btn_clear;
    logic       fb;
    logic [2:0] status;
    logic [2:0] digit_count;
    logic [1:0] tries_left;
    logic       lockout;

    always #5 clk = ~clk;

    access_control_unit #(
        .DIGIT_W     (4),
        .PW_LEN      (PW_LEN),
        .MAX_TRIES   (MAX_TRIES),
        .DENY_CYCLES (DENY),
        .LOCK_CYCLES (LOCK),
        .DEFAULT_PW  (16'h1234)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .enable               (enable),
        .access_control_reset (acr),
        .switches             (switches),
        .btn_enter            (btn_enter),
        .btn_clear            (btn_clear),
        .access_control_fb    (fb),
        .status               (status),
        .digit_count          (digit_count),
        .tries_left           (tries_left),
        .lockout              (lockout)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    int q[$];          // digits entered so far
    bit m_entry;       // an entry session is open
    bit m_check;       // a full password awaits comparison
    bit m_grant;
    int m_deny;        // cycles of denial remaining
    int m_lock;        // cycles of lockout remaining
    int m_tries;
    bit m_prev_e, m_prev_c;

    task automatic model_reset();
        q.delete();
        m_entry = 0; m_check = 0; m_grant = 0;
        m_deny = 0; m_lock = 0; m_tries = MAX_TRIES;
        m_prev_e = 1; m_prev_c = 1;
    endtask

    task automatic model_step();
        bit pe, pc;
        int v;
        pe = enable && btn_enter && !m_prev_e;
        pc = enable && btn_clear && !m_prev_c;
        m_prev_e = btn_enter;
        m_prev_c = btn_clear;
        if (m_lock > 0) begin
            m_lock--;
            if (m_lock == 0) m_tries = MAX_TRIES;
        end else if (!acr) begin
            q.delete(); m_entry = 0; m_check = 0; m_grant = 0; m_deny = 0;
        end else if (m_check) begin
            v = 0;
            foreach (q[i]) v = v * 16 + q[i];
            q.delete();
            m_check = 0;
            if (v == 'h1234) begin
                m_grant = 1; m_tries = MAX_TRIES;
            end else if (m_tries > 1) begin
                m_tries--; m_deny = DENY;
            end else begin
                m_tries = 0; m_lock = LOCK;
            end
        end else if (m_grant) begin
            // session held
        end else if (m_deny > 0) begin
            m_deny--;
        end else if (pc) begin
            if (m_entry) begin
                if (q.size() == 0) m_entry = 0;
                q.delete();
            end
        end else if (pe) begin
            q.push_back(int'(switches));
            m_entry = 1;
            if (q.size() == PW_LEN) begin
                m_entry = 0; m_check = 1;
            end
        end
    endtask

    function automatic int m_status();
        if (m_lock > 0)            return 4;
        if (m_grant)               return 2;
        if (m_deny > 0)            return 3;
        if (m_check || m_entry)    return 1;
        return 0;
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) model_reset();
            else      model_step();
        end
    end

    // Per-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            chk("cyc_status",  int'(status),      m_status());
            chk("cyc_count",   int'(digit_count), q.size());
            chk("cyc_tries",   int'(tries_left),  m_tries);
            chk("cyc_fb",      int'(fb),          int'(m_grant));
            chk("cyc_lockout", int'(lockout),     int'(m_lock > 0));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic press_hold(input logic [3:0] d);
        switches  = d;
        btn_enter = 1'b1;
        @(negedge clk);
        btn_enter = 1'b0;
    endtask

    task automatic press(input logic [3:0] d);
        press_hold(d);
        @(negedge clk);
    endtask

    task automatic logout();
        acr = 1'b0;
        @(negedge clk);
        acr = 1'b1;
    endtask

    int pw[4] = '{1, 2, 3, 4};

    initial begin
        rst = 1'b0; enable = 1'b1; acr = 1'b1;
        switches = 4'd0; btn_enter = 1'b0; btn_clear = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        chk("reset_status",  int'(status), 0);
        chk("reset_tries",   int'(tries_left), 3);
        chk("reset_count",   int'(digit_count), 0);
        chk("reset_lockout", int'(lockout), 0);
        @(negedge clk);

        // Correct password and grant latency
        press(4'd1); chk("t1_count1", int'(digit_count), 1);
        press(4'd2); chk("t1_count2", int'(digit_count), 2);
        press(4'd3); chk("t1_count3", int'(digit_count), 3);
        press_hold(4'd4);
        chk("t1_count4", int'(digit_count), 4);
        chk("t1_fb_early", int'(fb), 0);
        @(negedge clk);
        chk("t1_fb", int'(fb), 1);
        chk("t1_status", int'(status), 2);
        chk("t1_tries", int'(tries_left), 3);

        // Logout, then presses while disabled are ignored
        logout();
        chk("t5_fb_off", int'(fb), 0);
        chk("t5_status", int'(status), 0);
        enable = 1'b0;
        press(4'd1); press(4'd2);
        chk("t5_disabled_count", int'(digit_count), 0);
        enable = 1'b1;

        // Wrong password -> denied for DENY cycles
        press(4'd1); press(4'd2); press(4'd3); press_hold(4'd5);
        @(negedge clk);
        chk("t2_status_denied", int'(status), 3);
        chk("t2_tries", int'(tries_left), 2);
        repeat (7) @(negedge clk);
        chk("t2_still_denied", int'(status), 3);
        @(negedge clk);
        chk("t2_idle", int'(status), 0);
        chk("t2_fb", int'(fb), 0);

        // Second wrong, then third -> lockout that survives logout
        repeat (4) press(4'd9);
        repeat (10) @(negedge clk);
        chk("t3_tries1", int'(tries_left), 1);
        repeat (3) press(4'd9);
        press_hold(4'd9);
        @(negedge clk);
        chk("t3_locked", int'(status), 4);
        chk("t3_lockout", int'(lockout), 1);
        acr = 1'b0;
        repeat (3) @(negedge clk);
        acr = 1'b1;
        chk("t3_lock_survives", int'(status), 4);
        repeat (28) @(negedge clk);
        chk("t3_lock_end", int'(lockout), 1);
        @(negedge clk);
        chk("t3_after_status", int'(status), 0);
        chk("t3_after_tries", int'(tries_left), 3);

        // Enter and clear pressed together: clear wins
        press(4'd1); press(4'd2);
        switches = 4'd3; btn_enter = 1'b1; btn_clear = 1'b1;
        @(negedge clk);
        btn_enter = 1'b0; btn_clear = 1'b0;
        @(negedge clk);
        chk("t4_cleared_count", int'(digit_count), 0);
        chk("t4_still_entry", int'(status), 1);
        press(4'd1); press(4'd2); press(4'd3); press_hold(4'd4);
        @(negedge clk);
        chk("t4_granted", int'(fb), 1);
        logout();

        // Session clear wins over a simultaneous enter press
        acr = 1'b0;
        press(4'd1);
        acr = 1'b1;
        chk("t5_acr_wins", int'(digit_count), 0);

        // Enter held through reset release produces no press
        btn_enter = 1'b1; switches = 4'd1;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("t6_held_count", int'(digit_count), 0);
        btn_enter = 1'b0;
        @(negedge clk);

        // Async reset mid-entry restores everything immediately
        repeat (4) press(4'd9);
        repeat (10) @(negedge clk);
        press(4'd1); press(4'd2); press(4'd3);
        chk("t6_pre_count", int'(digit_count), 3);
        chk("t6_pre_tries", int'(tries_left), 2);
        #2 rst = 1'b0;
        #1;
        chk("t6_async_count", int'(digit_count), 0);
        chk("t6_async_tries", int'(tries_left), 3);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rst       = 1'b1;
            enable    = ($urandom % 10) != 0;
            acr       = ($urandom % 50) != 0;
            btn_clear = ($urandom % 25) == 0;
            btn_enter = ($urandom % 3) == 0;
            if (q.size() < 4 && ($urandom % 5) != 0) switches = 4'(pw[q.size()]);
            else                                     switches = 4'($urandom % 16);
            if (($urandom % 800) == 0) begin
                #2 rst = 1'b0;
            end
            @(negedge clk);
        end
        rst = 1'b1; btn_enter = 1'b0; btn_clear = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_access_control_unit
`default_nettype wire

// File: doc/access_control_unit.md
Name: access_control_unit

Overview:
Responder side of the access-control handshake driven by the top-level process controller. It collects a PW_LEN-digit password from the switches, one digit per enter-button press, and compares it against a stored password. It reports a granted session on access_control_fb and enforces a retry limit with a timed lockout. Session teardown comes from the controller's active-low access_control_reset level.

Parameters:
DIGIT_W, 4, width of one password digit (switch bank width)
PW_LEN, 4, digits per password
MAX_TRIES, 3, failed attempts before lockout
DENY_CYCLES, 8, clk cycles the DENIED state is held
LOCK_CYCLES, 32, clk cycles the LOCKED state is held
DEFAULT_PW, 16'h1234, stored password, most significant digit entered first

Ports:
clk  in  1  system clock; all state changes on posedge
rst  in  1  asynchronous, active-low reset
enable  in  1  high when the controller routes buttons/switches to this block; low = all button input ignored
access_control_reset  in  1  active-low session clear from controller; level, sampled on clk
switches  in  DIGIT_W  digit value captured on each enter press
btn_enter  in  1  enter button, level (already debounced)
btn_clear  in  1  clear button, level (already debounced)
access_control_fb  out  1  high while a session is granted
status  out  3  LCD/LED code: 0 IDLE, 1 ENTRY, 2 GRANTED, 3 DENIED, 4 LOCKED
digit_count  out  3  digits entered so far (0..PW_LEN)
tries_left  out  2  remaining attempts before lockout
lockout  out  1  high in LOCKED

Behaviour:
- Async reset: state IDLE, access_control_fb=0, status=0, digit_count=0, tries_left=MAX_TRIES, lockout=0, digit buffer=0, timer=0.
- Reset also sets both button-history flops to 1, so a button held through reset produces no press.
- Press detect: press = enable & btn & ~btn_prev. btn_prev updates every cycle, including when enable is low.
- States:
  - IDLE: the first enter press stores the digit, sets digit_count=1 and moves to ENTRY.
  - ENTRY: each enter press shifts switches into the buffer LSB-side and increments digit_count. When digit_count reaches PW_LEN, move to CHECK on the same edge. A clear press zeroes the buffer, sets digit_count=0 and stays in ENTRY (IDLE if no digits were entered).
  - CHECK: one cycle, buffer == DEFAULT_PW.
    - Match: GRANTED, tries_left=MAX_TRIES.
    - Mismatch with tries_left>1: decrement tries_left, load timer=DENY_CYCLES-1, go to DENIED.
    - Mismatch with tries_left==1: tries_left=0, load timer=LOCK_CYCLES-1, go to LOCKED.
    - digit_count clears on CHECK exit.
  - GRANTED: access_control_fb=1; all presses ignored. Stays until access_control_reset is sampled 0, then IDLE and fb=0 on that edge.
  - DENIED: timer counts down; at 0 go to IDLE. Presses ignored.
  - LOCKED: lockout=1; timer counts down; at 0 go to IDLE with tries_left=MAX_TRIES, lockout=0.
- Latency: access_control_fb rises on the second posedge after the posedge that samples the final enter press (capture edge, then CHECK edge).
- access_control_reset=0: forces IDLE, clears buffer and digit_count from IDLE, ENTRY, CHECK, DENIED and GRANTED. It does NOT affect LOCKED (lockout survives logout) or tries_left (only a match or lockout expiry restores it).
- Same cycle enter and clear press: clear wins, no digit stored.
- Same cycle access_control_reset=0 and enter press: reset wins.
- enable low mid-entry: buffer and digit_count hold; entry resumes when enable returns.
- Async rst mid-operation: immediate return to reset values, including tries_left.
- Timer width: clog2 of max(DENY_CYCLES, LOCK_CYCLES). No wrap is possible, because the timer is loaded only on CHECK exit.
- Outputs are registered; status is a registered encode of the state.

Decomposition:
- Shared package: status code constants (ST_IDLE..ST_LOCKED), the state encoding, and DEFAULT_PW.
- One natural sub-module: button_edge (per-button rising-edge detector with reset-to-1 history and enable gating), instantiated twice.

Test Plan:
- Enter 1,2,3,4 with enable=1 -> digit_count 1..4; access_control_fb=1 and status=2 on the second edge after the 4th press; tries_left=3.
- Enter 1,2,3,5 -> status=3, tries_left=2 for 8 cycles, then status=0, fb stays 0.
- Three wrong passwords -> lockout=1, status=4 for 32 cycles; access_control_reset=0 during lockout has no effect; afterwards tries_left=3, status=0.
- Enter 1,2, then enter+clear pressed the same cycle -> digit_count=0, buffer=0; then 1,2,3,4 -> granted.
- Granted session, drive access_control_reset=0 for one cycle -> fb=0 and status=0 next edge; enable=0 with enter presses -> digit_count stays 0.
- btn_enter held high across rst deassertion -> no digit captured; assert rst mid-entry after 3 digits -> digit_count=0, tries_left=3 immediately.
